count_hex_scan: RTL
===================

Name: count_hex_scan

Overview:
- Downstream consumer of the 4-bit free-running counter.
- Keeps a history of the last four distinct counter values.
- Drives a 4-digit, common-anode, multiplexed 7-segment display: digit 0 shows the newest value, digit 3 the oldest.
- Sits between the counter output and the board display pins; one clock domain.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays lit before the scan advances (>=2).
- PW, 16: width of the prescaler counter; must satisfy 2^PW >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- count  input  4  counter value from the upstream counter stage.
- freeze  input  1  1 = hold history; counter changes are ignored.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anodes, active-low, one-hot when lit; an[i] = digit i.
- dp  output  1  decimal point, active-low.
- upd  output  1  one-cycle pulse, the cycle after history is written.

Behaviour:
Reset (rst=1 at posedge):
- h0..h3 = 0, valid v[3:0] = 0, last = 0, primed = 0.
- idx = 0, prescaler = 0.
- seg = 7'h7F, an = 4'hF, dp = 1, upd = 0.
- Reset mid-scan or mid-update discards everything; no pulse is emitted for in-flight work.

Capture:
- Each cycle the block computes write = !freeze && (!primed || count != last).
- On write:
  - h3<=h2, h2<=h1, h1<=h0, h0<=count.
  - v <= {v[2:0],1'b1}, last <= count, primed <= 1.
  - upd = 1 next cycle.
- The first non-frozen cycle after reset always writes, even if count = 0.
- Wrap 15->0 is a change like any other.
- While freeze=1: no write, last is not updated, and changes are lost. The first non-frozen cycle whose count differs from last writes.
- Simultaneous write and scan advance: both take effect. Display uses the pre-write history this cycle and the new history from the next cycle.

Scan:
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the wrap cycle, idx <= idx+1 (mod 4: 0,1,2,3,0).
- Outputs are registered from the current idx and history, 1-cycle latency:
  - an <= ~(1<<idx).
  - seg <= v[idx] ? hex(h[idx]) : 7'h7F.
  - dp <= ~(freeze && idx==0).
- Invalid (never-written) digits have the anode driven but all segments off.

Hex decode, active-low {g..a}:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)

Test Plan:
- rst held 3 cycles with count=5 -> seg=7F, an=F, dp=1, upd=0. First cycle after release writes h0=5, v=0001, upd=1 one cycle later. With REFRESH_DIV=4, an cycles E,D,B,7 every 4 clks, seg=12 on digit 0 and 7F on the others.
- count steps 3,4,5,6,7 one per cycle -> five upd pulses; final h0..h3 = 7,6,5,4. Digits show 78,02,12,19.
- count 14,15,0 -> 15->0 write occurs; h0=0 shows seg=40 and h1=F shows 0E.
- count constant 9 for 20 cycles after the first write -> exactly one upd pulse, history unchanged.
- freeze=1, count 1->2->3, then freeze=0 with count=3 -> no writes while frozen, one write of 3 on release. dp=0 only while an=E during freeze.
- rst asserted mid-scan at idx=2 with v=1111 -> next cycle an=F, seg=7F. After release, scan restarts at digit 0 and only the first capture is displayed.

Source files
------------

// File: rtl/count_hex_scan.sv
`default_nettype none
// ============================================================================
//  Module      : count_hex_scan
//  Description : Keeps the last four distinct values of an upstream 4-bit
//                counter and shows them on a 4-digit, common-anode,
//                multiplexed 7-segment display (digit 0 = newest).
//  Revision    : 1.0 - initial release
// ============================================================================
module count_hex_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int PW          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       freeze,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       upd
);

    localparam logic [PW-1:0] c_PRE_MAX  = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]    c_SEG_OFF  = 7'h7F;

    logic [3:0]    r_h [4];
    logic [3:0]    r_v;
    logic [3:0]    r_last;
    logic          r_primed;
    logic [1:0]    r_idx;
    logic [PW-1:0] r_pre;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_dp;
    logic          r_upd;

    logic          w_write;
    logic          w_wrap;
    logic [3:0]    w_digit;
    logic [6:0]    w_hex;
    logic [6:0]    w_seg_nxt;

    // Write on the first unfrozen cycle after reset, then only on a change.
    always_comb begin
        w_write = !freeze && (!r_primed || (count != r_last));
        w_wrap  = (r_pre == c_PRE_MAX);
    end

    // Hex decode of the digit currently selected by the scan index.
    always_comb begin
        w_digit = r_h[r_idx];
        w_hex   = c_SEG_OFF;
        case (w_digit)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = c_SEG_OFF;
        endcase
        // Never-written digits keep their anode but show nothing.
        w_seg_nxt = r_v[r_idx] ? w_hex : c_SEG_OFF;
    end

    // History shift register, valid flags and change tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h[0]   <= 4'h0;
            r_h[1]   <= 4'h0;
            r_h[2]   <= 4'h0;
            r_h[3]   <= 4'h0;
            r_v      <= 4'h0;
            r_last   <= 4'h0;
            r_primed <= 1'b0;
            r_upd    <= 1'b0;
        end else begin
            r_upd <= w_write;
            if (w_write) begin
                r_h[3]   <= r_h[2];
                r_h[2]   <= r_h[1];
                r_h[1]   <= r_h[0];
                r_h[0]   <= count;
                r_v      <= {r_v[2:0], 1'b1};
                r_last   <= count;
                r_primed <= 1'b1;
            end
        end
    end

    // Refresh prescaler; the digit index advances on each prescaler wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Registered display drive from the pre-write history and current index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= c_SEG_OFF;
            r_an  <= 4'hF;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= ~(4'b0001 << r_idx);
            r_dp  <= ~(freeze && (r_idx == 2'd0));
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;
    assign upd = r_upd;

endmodule
`default_nettype wire
